// File: rtl/fetch_pc_ctrl.sv
// PC / instruction-fetch sequencer for the multicycle core: one fetch per instruction,
// buffers the returned word, and drives PC register updates (PC+4, branch, trap, mret).
module fetch_pc_ctrl #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   i_stall,
  input  logic [DATA_WIDTH-1:0]  i_pc,
  output logic                   o_pc_write_en,
  output logic [DATA_WIDTH-1:0]  o_pc_next,
  output logic                   o_fetch_req,
  output logic [DATA_WIDTH-1:0]  o_fetch_addr,
  input  logic                   i_fetch_ack,
  input  logic [INSTR_WIDTH-1:0] i_fetch_data,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0]  o_instr_pc,
  input  logic                   i_instr_accept,
  input  logic                   i_branch_taken,
  input  logic [DATA_WIDTH-1:0]  i_branch_target,
  input  logic                   i_trap,
  input  logic [DATA_WIDTH-1:0]  i_mtvec,
  input  logic                   i_mret,
  input  logic [DATA_WIDTH-1:0]  i_mepc,
  output logic                   o_misaligned
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t                  state;
  logic                    pend_valid;
  logic                    pend_trap;
  logic [DATA_WIDTH-1:0]   pend_target;

  logic                    br_ok;
  logic                    br_bad;
  logic                    redir;
  logic [DATA_WIDTH-1:0]   redir_tgt;
  logic [DATA_WIDTH-1:0]   pc_plus4;

  // Redirect arbitration: trap > mret > aligned branch
  always_comb begin
    br_ok     = i_branch_taken && (i_branch_target[1:0] == 2'b00);
    br_bad    = i_branch_taken && !i_trap && !i_mret && (i_branch_target[1:0] != 2'b00);
    redir     = i_trap || i_mret || br_ok;
    redir_tgt = i_trap ? i_mtvec : (i_mret ? i_mepc : i_branch_target);
    pc_plus4  = i_pc + DATA_WIDTH'(4);
  end

  // PC write port is combinational so the PC register updates on the next edge
  always_comb begin
    o_pc_write_en = 1'b0;
    o_pc_next     = '0;
    case (state)
      IDLE: begin
        if (redir) begin
          o_pc_write_en = 1'b1;
          o_pc_next     = redir_tgt;
        end
      end
      FETCH: begin
        if (i_fetch_ack) begin
          o_pc_write_en = 1'b1;
          if (redir)           o_pc_next = redir_tgt;
          else if (pend_valid) o_pc_next = pend_target;
          else                 o_pc_next = pc_plus4;
        end
      end
      HOLD: begin
        if (redir) begin
          o_pc_write_en = 1'b1;
          o_pc_next     = redir_tgt;
        end
      end
      default: ;
    endcase
    if (arst) begin
      o_pc_write_en = 1'b0;
      o_pc_next     = '0;
    end
  end

  assign o_fetch_req   = (state == FETCH);
  assign o_fetch_addr  = o_fetch_req ? i_pc : '0;
  assign o_instr_valid = (state == HOLD);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state        <= IDLE;
      pend_valid   <= 1'b0;
      pend_trap    <= 1'b0;
      pend_target  <= '0;
      o_instr      <= '0;
      o_instr_pc   <= '0;
      o_misaligned <= 1'b0;
    end else begin
      o_misaligned <= br_bad;
      case (state)
        IDLE: begin
          if (redir || !i_stall) state <= FETCH;
        end
        FETCH: begin
          if (i_fetch_ack) begin
            if (redir || pend_valid) begin
              // Stale fetch: data dropped, request reissued at the new PC
              pend_valid <= 1'b0;
              pend_trap  <= 1'b0;
            end else begin
              o_instr    <= i_fetch_data;
              o_instr_pc <= i_pc;
              state      <= HOLD;
            end
          end else if (redir && !(pend_valid && pend_trap && !i_trap)) begin
            // A held trap may only be displaced by a newer trap
            pend_valid  <= 1'b1;
            pend_trap   <= i_trap;
            pend_target <= redir_tgt;
          end
        end
        HOLD: begin
          if (redir || (i_instr_accept && !i_stall)) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl; models the external PC register (reset vector 0x3000_0000).
module tb_fetch_pc_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned IW = 32;
  localparam logic [DW-1:0] RST_VEC = 64'h0000_0000_3000_0000;

  logic          clk = 1'b0;
  logic          arst;
  logic          i_stall;
  logic [DW-1:0] pc;
  logic          o_pc_write_en;
  logic [DW-1:0] o_pc_next;
  logic          o_fetch_req;
  logic [DW-1:0] o_fetch_addr;
  logic          i_fetch_ack;
  logic [IW-1:0] i_fetch_data;
  logic          o_instr_valid;
  logic [IW-1:0] o_instr;
  logic [DW-1:0] o_instr_pc;
  logic          i_instr_accept;
  logic          i_branch_taken;
  logic [DW-1:0] i_branch_target;
  logic          i_trap;
  logic [DW-1:0] i_mtvec;
  logic          i_mret;
  logic [DW-1:0] i_mepc;
  logic          o_misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .arst(arst), .i_stall(i_stall), .i_pc(pc),
    .o_pc_write_en(o_pc_write_en), .o_pc_next(o_pc_next),
    .o_fetch_req(o_fetch_req), .o_fetch_addr(o_fetch_addr),
    .i_fetch_ack(i_fetch_ack), .i_fetch_data(i_fetch_data),
    .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
    .i_instr_accept(i_instr_accept),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_trap(i_trap), .i_mtvec(i_mtvec), .i_mret(i_mret), .i_mepc(i_mepc),
    .o_misaligned(o_misaligned)
  );

  // External PC register
  always_ff @(posedge clk or posedge arst) begin
    if (arst)               pc <= RST_VEC;
    else if (o_pc_write_en) pc <= o_pc_next;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle: inputs change just after the falling edge
  task automatic next_cyc();
    @(negedge clk);
    i_stall = 1'b0; i_fetch_ack = 1'b0; i_fetch_data = '0; i_instr_accept = 1'b0;
    i_branch_taken = 1'b0; i_branch_target = '0; i_trap = 1'b0; i_mtvec = '0;
    i_mret = 1'b0; i_mepc = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".we"},    64'(o_pc_write_en), 64'h0);
    chk({tag, ".next"},  o_pc_next,          64'h0);
    chk({tag, ".req"},   64'(o_fetch_req),   64'h0);
    chk({tag, ".addr"},  o_fetch_addr,       64'h0);
    chk({tag, ".valid"}, 64'(o_instr_valid), 64'h0);
    chk({tag, ".instr"}, 64'(o_instr),       64'h0);
    chk({tag, ".ipc"},   o_instr_pc,         64'h0);
    chk({tag, ".mis"},   64'(o_misaligned),  64'h0);
  endtask

  initial begin
    arst = 1'b1;
    next_cyc();
    next_cyc();
    #1 chk_all_zero("reset");

    // IDLE -> FETCH
    arst = 1'b0;
    #1 chk("idle.req", 64'(o_fetch_req), 64'h0);
    next_cyc();
    #1 chk("f1.req", 64'(o_fetch_req), 64'h1);
    chk("f1.addr", o_fetch_addr, 64'h3000_0000);
    chk("f1.we", 64'(o_pc_write_en), 64'h0);
    next_cyc();
    i_fetch_ack = 1'b1; i_fetch_data = 32'h0000_0013;
    #1 chk("ack1.we", 64'(o_pc_write_en), 64'h1);
    chk("ack1.next", o_pc_next, 64'h3000_0004);
    next_cyc();
    i_instr_accept = 1'b1;
    #1 chk("hold1.valid", 64'(o_instr_valid), 64'h1);
    chk("hold1.instr", 64'(o_instr), 64'h13);
    chk("hold1.ipc", o_instr_pc, 64'h3000_0000);
    chk("hold1.req", 64'(o_fetch_req), 64'h0);
    chk("hold1.we", 64'(o_pc_write_en), 64'h0);

    // Branch while fetch in flight: pending, stale data dropped
    next_cyc();
    i_branch_taken = 1'b1; i_branch_target = 64'h3000_0100;
    #1 chk("f2.valid", 64'(o_instr_valid), 64'h0);
    chk("f2.addr", o_fetch_addr, 64'h3000_0004);
    chk("f2.we", 64'(o_pc_write_en), 64'h0);
    next_cyc();
    i_fetch_ack = 1'b1; i_fetch_data = 32'hdead_beef;
    #1 chk("f2ack.we", 64'(o_pc_write_en), 64'h1);
    chk("f2ack.next", o_pc_next, 64'h3000_0100);
    next_cyc();
    i_fetch_ack = 1'b1; i_fetch_data = 32'h0010_0093;
    #1 chk("f3.valid", 64'(o_instr_valid), 64'h0);
    chk("f3.req", 64'(o_fetch_req), 64'h1);
    chk("f3.addr", o_fetch_addr, 64'h3000_0100);
    chk("f3.next", o_pc_next, 64'h3000_0104);

    // Trap + misaligned branch + accept in HOLD: trap wins
    next_cyc();
    i_trap = 1'b1; i_mtvec = 64'h3000_0200;
    i_branch_taken = 1'b1; i_branch_target = 64'h3000_0102; i_instr_accept = 1'b1;
    #1 chk("h2.instr", 64'(o_instr), 64'h0010_0093);
    chk("h2.ipc", o_instr_pc, 64'h3000_0100);
    chk("h2.we", 64'(o_pc_write_en), 64'h1);
    chk("h2.next", o_pc_next, 64'h3000_0200);

    // Misaligned branch alone: pulse, no write, no pending
    next_cyc();
    i_branch_taken = 1'b1; i_branch_target = 64'h3000_0102;
    #1 chk("f4.valid", 64'(o_instr_valid), 64'h0);
    chk("f4.mis", 64'(o_misaligned), 64'h0);
    chk("f4.addr", o_fetch_addr, 64'h3000_0200);
    chk("f4.we", 64'(o_pc_write_en), 64'h0);
    next_cyc();
    i_fetch_ack = 1'b1; i_fetch_data = 32'h0000_0013;
    #1 chk("f4b.mis", 64'(o_misaligned), 64'h1);
    chk("f4b.addr", o_fetch_addr, 64'h3000_0200);
    chk("f4b.next", o_pc_next, 64'h3000_0204);

    // mret in HOLD to top of address space, then wrap
    next_cyc();
    i_mret = 1'b1; i_mepc = 64'hFFFF_FFFF_FFFF_FFFC;
    #1 chk("h3.mis", 64'(o_misaligned), 64'h0);
    chk("h3.ipc", o_instr_pc, 64'h3000_0200);
    chk("h3.next", o_pc_next, 64'hFFFF_FFFF_FFFF_FFFC);
    next_cyc();
    i_fetch_ack = 1'b1; i_fetch_data = 32'h0000_0013;
    #1 chk("wrap.addr", o_fetch_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap.we", 64'(o_pc_write_en), 64'h1);
    chk("wrap.next", o_pc_next, 64'h0);

    // Stall blocks accept
    next_cyc();
    i_instr_accept = 1'b1; i_stall = 1'b1;
    #1 chk("h4.ipc", o_instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("h4.we", 64'(o_pc_write_en), 64'h0);
    next_cyc();
    i_instr_accept = 1'b1;
    #1 chk("h4b.valid", 64'(o_instr_valid), 64'h1);

    // Pending trap survives a later branch
    next_cyc();
    i_trap = 1'b1; i_mtvec = 64'h3000_0200;
    #1 chk("f5.addr", o_fetch_addr, 64'h0);
    chk("f5.we", 64'(o_pc_write_en), 64'h0);
    next_cyc();
    i_branch_taken = 1'b1; i_branch_target = 64'h3000_0300;
    #1 chk("f5b.we", 64'(o_pc_write_en), 64'h0);
    next_cyc();
    i_fetch_ack = 1'b1; i_fetch_data = 32'hdead_beef;
    #1 chk("f5c.next", o_pc_next, 64'h3000_0200);

    // Current-cycle redirect beats pending branch
    next_cyc();
    i_branch_taken = 1'b1; i_branch_target = 64'h3000_0400;
    #1 chk("f6.addr", o_fetch_addr, 64'h3000_0200);
    next_cyc();
    i_fetch_ack = 1'b1; i_mret = 1'b1; i_mepc = 64'h3000_0500;
    #1 chk("f6b.next", o_pc_next, 64'h3000_0500);

    // Async reset with a pending trap held
    next_cyc();
    i_trap = 1'b1; i_mtvec = 64'h3000_0600;
    #1 chk("f7.addr", o_fetch_addr, 64'h3000_0500);
    next_cyc();
    i_branch_taken = 1'b1; i_branch_target = 64'h3000_0700;
    #2 arst = 1'b1;
    #1 chk_all_zero("arst");
    next_cyc();
    arst = 1'b0;
    i_stall = 1'b1; i_branch_taken = 1'b1; i_branch_target = 64'h3000_0800;
    #1 chk("idle2.req", 64'(o_fetch_req), 64'h0);
    chk("idle2.we", 64'(o_pc_write_en), 64'h1);
    chk("idle2.next", o_pc_next, 64'h3000_0800);
    next_cyc();
    i_fetch_ack = 1'b1; i_fetch_data = 32'h0020_0113;
    #1 chk("f8.addr", o_fetch_addr, 64'h3000_0800);
    chk("f8.next", o_pc_next, 64'h3000_0804);
    next_cyc();
    #1 chk("h8.valid", 64'(o_instr_valid), 64'h1);
    chk("h8.instr", 64'(o_instr), 64'h0020_0113);
    chk("h8.ipc", o_instr_pc, 64'h3000_0800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
